flag_ckpt_reg: RTL and testbench
================================

Name: flag_ckpt_reg

Overview:
Parametrised successor to the CPU's 3-bit condition flag register (Z/V/N).
- Adds per-bit write masking and optional same-cycle bypass.
- Adds a FIFO of flag checkpoints so the pipeline can restore flags on a branch mispredict.
- Sits between the ALU flag outputs and the branch-condition logic in the decode/execute stage.

Parameters:
NFLAG, 3, number of flag bits
DEPTH, 4, checkpoint slots (>=1; pointers wrap modulo DEPTH, power of two not required)
BYPASS, 0, 1 = flag output shows the masked write value in the same cycle
RESET_VAL, 0, NFLAG-bit value loaded into the flags on reset

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous, active-low reset
we  in  1  flag write enable
wmask  in  NFLAG  per-bit write mask (1 = update bit)
new_flag  in  NFLAG  new flag values from the ALU
flag  out  NFLAG  current flags
ckpt_push  in  1  snapshot the current flags (branch issued)
ckpt_release  in  1  discard the oldest snapshot (oldest branch predicted correctly)
ckpt_restore  in  1  oldest branch mispredicted: reload flags from the oldest snapshot, flush all snapshots
ckpt_count  out  $clog2(DEPTH+1)  valid snapshots held
ckpt_full  out  1  ckpt_count == DEPTH
ckpt_empty  out  1  ckpt_count == 0
err  out  1  sticky protocol error

Behaviour:
- Reset (rst_n low, async): flag register = RESET_VAL; rd/wr pointers = 0; count = 0; err = 0. Outputs take these values immediately. A reset mid-speculation discards all snapshots.
- Write: masked = (new_flag & wmask) | (reg & ~wmask). The register loads masked at the rising edge when we=1. Bits with wmask=0 hold. wmask=0 with we=1 is a legal no-op.
- flag output:
  - BYPASS=0: flag = reg (1-cycle write latency).
  - BYPASS=1: flag = we ? masked : reg (combinational, 0-cycle).
- Push: when not full, the slot at wr_ptr stores the value on flag in that cycle. With BYPASS=0 this is the pre-write value; with BYPASS=1 it is the bypassed value. Then wr_ptr++ (wrap) and count++.
- Release: when not empty, rd_ptr++ (wrap) and count--.
- Restore: when not empty, reg <= slot[rd_ptr]; rd_ptr = wr_ptr = 0; count = 0. we, push and release are ignored that cycle.
- Priority in one cycle: restore > (push, release, we).
- push + release together: both act and count is unchanged. This is legal even when full (the slot is freed in the same edge) or when empty (push then release; net count stays 0, pointers advance).
- push + we together: both act; the snapshot follows the rule above.
- Errors (err <= 1, held until reset): push when full and no release, release when empty and no push, restore when empty. The erroneous operation is dropped and no state changes from it. A restore when empty still blocks we that cycle.
- ckpt_full and ckpt_empty are decoded from the count register (no combinational path from the request inputs).

Decomposition:
- Package flag_pkg:
  - Flag index constants FLAG_Z=0, FLAG_V=1, FLAG_N=2.
  - Typedef flag_t (logic [2:0]).
  - Localparam helper for counter width.
- Sub-module flag_ckpt_fifo (parametrised WIDTH/DEPTH):
  - Contains the snapshot storage, pointers, count, full/empty and error detection.
  - Has push/pop/flush ports and exposes head data.
  - The top level keeps the flag register, mask/bypass logic and restore priority.

Test Plan:
1. Reset with RESET_VAL=3'b101, then release rst_n between edges -> flag=101, count=0, empty=1, err=0. Assert rst_n low asynchronously while count=2 -> count=0 and flag=101 immediately, with no clock edge.
2. BYPASS=0, reg=000, we=1, wmask=100, new_flag=111 -> flag=000 in that cycle and 100 after the edge. Then we=1, wmask=011, new_flag=001 -> 101. we=0 with new_flag=111 -> stays 101.
3. BYPASS=1, reg=000, we=1, wmask=111, new_flag=110 -> flag=110 in the same cycle. Push in the same cycle -> snapshot holds 110.
4. DEPTH=4, push with flags 001, 010, 011, 100 -> full=1, count=4. A 5th push alone -> err=1 and count=4. push+release while full -> count=4, err unchanged. Four releases -> empty=1, pointers wrapped.
5. Flags=001, push; write 111; push; write 000; restore -> flag=001, count=0. A we=1 issued on the restore cycle is ignored: flag=001 next cycle.
6. Restore when empty with we=1, new_flag=111 -> flag unchanged, err=1. A release when empty -> err stays 1 until rst_n is pulsed low.

Source files
------------

// File: rtl/flag_pkg.sv
// Shared definitions for the condition-flag register and its checkpoint FIFO.
package flag_pkg;

    // Bit positions of the architectural condition flags
    localparam int FLAG_Z = 0;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 2;

    typedef logic [2:0] flag_t;

    // Width of a counter that must hold values 0..depth inclusive
    function automatic int cnt_width(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/flag_ckpt_fifo.sv
// Checkpoint FIFO: snapshot storage, wrap-around pointers, occupancy count,
// full/empty decode and sticky protocol-error detection.
module flag_ckpt_fifo
    import flag_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        push,
    input  logic                        pop,
    input  logic                        flush,
    input  logic [WIDTH-1:0]            wr_data,
    output logic [WIDTH-1:0]            head,
    output logic [cnt_width(DEPTH)-1:0] count,
    output logic                        full,
    output logic                        empty,
    output logic                        err
);

    localparam int CW = cnt_width(DEPTH);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] slot_reg [DEPTH];
    logic [PW-1:0]    wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]    rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]    count_reg, count_next;
    logic             err_reg, err_next;
    logic             push_ok, pop_ok;

    // Flags come straight from the count register, never from the requests
    assign full  = (count_reg == FULL_CNT);
    assign empty = (count_reg == '0);
    assign count = count_reg;
    assign err   = err_reg;
    assign head  = slot_reg[rd_ptr_reg];

    // Next-state: flush wins; a simultaneous push+pop is legal at either extreme
    always_comb begin
        push_ok     = 1'b0;
        pop_ok      = 1'b0;
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        err_next    = err_reg;
        if (flush) begin
            if (empty) begin
                err_next = 1'b1;
            end else begin
                wr_ptr_next = '0;
                rd_ptr_next = '0;
                count_next  = '0;
            end
        end else begin
            push_ok = push && (!full || pop);
            pop_ok  = pop && (!empty || push);
            if ((push && full && !pop) || (pop && empty && !push)) begin
                err_next = 1'b1;
            end
            if (push_ok) begin
                wr_ptr_next = (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_next = (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                count_next = count_reg + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count_next = count_reg - 1'b1;
            end
        end
    end

    // Control state; reset abandons every outstanding snapshot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            err_reg    <= 1'b0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            err_reg    <= err_next;
        end
    end

    // Snapshot storage needs no reset: slots are only read after being written
    always_ff @(posedge clk) begin
        if (push_ok) begin
            slot_reg[wr_ptr_reg] <= wr_data;
        end
    end

endmodule

// File: rtl/flag_ckpt_reg.sv
// Condition-flag register with per-bit write mask, optional same-cycle bypass
// and a checkpoint FIFO used to roll flags back on a branch mispredict.
module flag_ckpt_reg
    import flag_pkg::*;
#(
    parameter int               NFLAG     = 3,
    parameter int               DEPTH     = 4,
    parameter int               BYPASS    = 0,
    parameter logic [NFLAG-1:0] RESET_VAL = '0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        we,
    input  logic [NFLAG-1:0]            wmask,
    input  logic [NFLAG-1:0]            new_flag,
    output logic [NFLAG-1:0]            flag,
    input  logic                        ckpt_push,
    input  logic                        ckpt_release,
    input  logic                        ckpt_restore,
    output logic [cnt_width(DEPTH)-1:0] ckpt_count,
    output logic                        ckpt_full,
    output logic                        ckpt_empty,
    output logic                        err
);

    logic [NFLAG-1:0] flag_reg, flag_next;
    logic [NFLAG-1:0] masked;
    logic [NFLAG-1:0] head;

    // Per-bit merge of the ALU result with the held value
    genvar gi;
    generate
        for (gi = 0; gi < NFLAG; gi++) begin : g_mask
            assign masked[gi] = wmask[gi] ? new_flag[gi] : flag_reg[gi];
        end
    endgenerate

    // Visible flags: either the register or the in-flight masked write
    generate
        if (BYPASS != 0) begin : g_bypass
            assign flag = we ? masked : flag_reg;
        end else begin : g_nobypass
            assign flag = flag_reg;
        end
    endgenerate

    // Restore owns the cycle; even an empty (erroneous) restore suppresses the write
    always_comb begin
        flag_next = flag_reg;
        if (ckpt_restore) begin
            if (!ckpt_empty) begin
                flag_next = head;
            end
        end else if (we) begin
            flag_next = masked;
        end
    end

    // Architectural flag register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_reg <= RESET_VAL;
        end else begin
            flag_reg <= flag_next;
        end
    end

    // Snapshots capture what the branch logic sees this cycle
    flag_ckpt_fifo #(
        .WIDTH (NFLAG),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (ckpt_push),
        .pop     (ckpt_release),
        .flush   (ckpt_restore),
        .wr_data (flag),
        .head    (head),
        .count   (ckpt_count),
        .full    (ckpt_full),
        .empty   (ckpt_empty),
        .err     (err)
    );

endmodule

// File: tb/tb_flag_ckpt_reg.sv
// Directed bench for flag_ckpt_reg: one non-bypass instance with a non-zero
// reset value and one bypass instance, checked against hand-computed values.
module tb_flag_ckpt_reg;

    logic clk;
    logic rst_n;

    // Instance 0: BYPASS=0, RESET_VAL=101
    logic       we0, push0, rel0, rest0;
    logic [2:0] wmask0, nf0, flag0;
    logic [2:0] cnt0;
    logic       full0, empty0, err0;

    // Instance 1: BYPASS=1, RESET_VAL=000
    logic       we1, push1, rel1, rest1;
    logic [2:0] wmask1, nf1, flag1;
    logic [2:0] cnt1;
    logic       full1, empty1, err1;

    int checks;
    int errors;

    flag_ckpt_reg #(
        .NFLAG (3), .DEPTH (4), .BYPASS (0), .RESET_VAL (3'b101)
    ) u_dut0 (
        .clk (clk), .rst_n (rst_n), .we (we0), .wmask (wmask0),
        .new_flag (nf0), .flag (flag0), .ckpt_push (push0),
        .ckpt_release (rel0), .ckpt_restore (rest0), .ckpt_count (cnt0),
        .ckpt_full (full0), .ckpt_empty (empty0), .err (err0)
    );

    flag_ckpt_reg #(
        .NFLAG (3), .DEPTH (4), .BYPASS (1), .RESET_VAL (3'b000)
    ) u_dut1 (
        .clk (clk), .rst_n (rst_n), .we (we1), .wmask (wmask1),
        .new_flag (nf1), .flag (flag1), .ckpt_push (push1),
        .ckpt_release (rel1), .ckpt_restore (rest1), .ckpt_count (cnt1),
        .ckpt_full (full1), .ckpt_empty (empty1), .err (err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0b exp=%0b t=%0t", tag, got, exp, $time);
        end else begin
            $display("ok   %s value=%0b t=%0t", tag, got, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] vals [4];
        vals[0] = 3'b001; vals[1] = 3'b010; vals[2] = 3'b011; vals[3] = 3'b100;
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        we0 = 0; push0 = 0; rel0 = 0; rest0 = 0; wmask0 = '0; nf0 = '0;
        we1 = 0; push1 = 0; rel1 = 0; rest1 = 0; wmask1 = '0; nf1 = '0;

        // 1. reset, released between edges
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        chk("rst_flag0", 32'(flag0), 32'b101);
        chk("rst_count0", 32'(cnt0), 0);
        chk("rst_empty0", 32'(empty0), 1);
        chk("rst_err0", 32'(err0), 0);
        chk("rst_flag1", 32'(flag1), 32'b000);

        // 2. BYPASS=0 masked writes
        we0 = 1; wmask0 = 3'b111; nf0 = 3'b000;
        step();
        chk("w_clear0", 32'(flag0), 32'b000);
        wmask0 = 3'b100; nf0 = 3'b111;
        #1;
        chk("w_nobypass_same", 32'(flag0), 32'b000);
        step();
        chk("w_mask100", 32'(flag0), 32'b100);
        wmask0 = 3'b011; nf0 = 3'b001;
        step();
        chk("w_mask011", 32'(flag0), 32'b101);
        we0 = 0; nf0 = 3'b111;
        step();
        chk("w_hold", 32'(flag0), 32'b101);

        // 3. BYPASS=1 same-cycle value, pushed snapshot
        we1 = 1; wmask1 = 3'b111; nf1 = 3'b110; push1 = 1;
        #1;
        chk("byp_same", 32'(flag1), 32'b110);
        step();
        we1 = 0; push1 = 0;
        #1;
        chk("byp_count", 32'(cnt1), 1);
        chk("byp_reg", 32'(flag1), 32'b110);
        we1 = 1; nf1 = 3'b000;
        step();
        we1 = 0;
        #1;
        chk("byp_clear", 32'(flag1), 32'b000);
        rest1 = 1;
        step();
        rest1 = 0;
        #1;
        chk("byp_snap", 32'(flag1), 32'b110);
        chk("byp_rest_cnt", 32'(cnt1), 0);
        // push+release while empty: net count 0, no error
        push1 = 1; rel1 = 1;
        step();
        push1 = 0; rel1 = 0;
        chk("empty_pr_cnt", 32'(cnt1), 0);
        chk("empty_pr_err", 32'(err1), 0);

        // 4. fill, overflow, drain
        for (int i = 0; i < 4; i++) begin
            we0 = 1; wmask0 = 3'b111; nf0 = vals[i];
            step();
            we0 = 0; push0 = 1;
            step();
            push0 = 0;
        end
        chk("fill_count", 32'(cnt0), 4);
        chk("fill_full", 32'(full0), 1);
        chk("fill_err", 32'(err0), 0);
        push0 = 1; rel0 = 1;
        step();
        push0 = 0; rel0 = 0;
        chk("full_pr_cnt", 32'(cnt0), 4);
        chk("full_pr_err", 32'(err0), 0);
        push0 = 1;
        step();
        push0 = 0;
        chk("ovf_err", 32'(err0), 1);
        chk("ovf_cnt", 32'(cnt0), 4);
        for (int i = 0; i < 4; i++) begin
            rel0 = 1;
            step();
            rel0 = 0;
            chk($sformatf("drain_%0d", i), 32'(cnt0), 32'(3 - i));
        end
        chk("drain_empty", 32'(empty0), 1);

        // 5. checkpoint/restore across wrapped pointers
        we0 = 1; wmask0 = 3'b111; nf0 = 3'b001;
        step();
        nf0 = 3'b111; push0 = 1;   // snapshot takes pre-write 001
        step();
        we0 = 0;                   // snapshot 111
        step();
        push0 = 0;
        chk("ck_cnt2", 32'(cnt0), 2);
        we0 = 1; nf0 = 3'b000;
        step();
        chk("ck_flag000", 32'(flag0), 32'b000);
        rest0 = 1; nf0 = 3'b110;
        step();
        rest0 = 0; we0 = 0;
        chk("rest_flag", 32'(flag0), 32'b001);
        chk("rest_cnt", 32'(cnt0), 0);
        step();
        chk("rest_hold", 32'(flag0), 32'b001);

        // async reset mid-speculation
        push0 = 1;
        step();
        step();
        push0 = 0;
        chk("spec_cnt2", 32'(cnt0), 2);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_cnt", 32'(cnt0), 0);
        chk("arst_flag", 32'(flag0), 32'b101);
        chk("arst_err", 32'(err0), 0);
        #2 rst_n = 1'b1;

        // 6. restore and release when empty
        rest0 = 1; we0 = 1; wmask0 = 3'b111; nf0 = 3'b111;
        step();
        rest0 = 0; we0 = 0;
        chk("er_flag", 32'(flag0), 32'b101);
        chk("er_err", 32'(err0), 1);
        rel0 = 1;
        step();
        rel0 = 0;
        step();
        chk("er_sticky", 32'(err0), 1);
        chk("er_cnt", 32'(cnt0), 0);
        #3 rst_n = 1'b0;
        #1;
        chk("er_cleared", 32'(err0), 0);
        #2 rst_n = 1'b1;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
